// File: rtl/loan_io_pkg.sv
// Shared constants and types for the HPS loan-IO controller.
package loan_io_pkg;

  localparam int LOAN_W  = 67;
  localparam int PIN_TX  = 49;
  localparam int PIN_RX  = 50;
  localparam int PIN_LED = 53;
  localparam int PIN_KEY = 54;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_ACT   = 2'b11
  } led_mode_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

endpackage

// File: rtl/loan_io_uart_tx.sv
// 8N1 UART transmitter, LSB first, every bit held BAUD_DIV clocks.
module loan_io_uart_tx
  import loan_io_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_line
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_done;

  assign bit_done = (baud_cnt == BIT_LAST);

  // Frame sequencer: line level and ready are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= UART_IDLE;
      tx_line  <= 1'b1;
      tx_ready <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        UART_IDLE: begin
          tx_line  <= 1'b1;
          baud_cnt <= '0;
          if (tx_valid) begin
            state    <= UART_START;
            tx_line  <= 1'b0;
            tx_ready <= 1'b0;
          end
        end
        UART_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= UART_DATA;
            tx_line  <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        UART_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= UART_STOP;
              tx_line <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_line <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        UART_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= UART_IDLE;
            tx_ready <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= UART_IDLE;
          tx_line  <= 1'b1;
          tx_ready <= 1'b1;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // Byte shifter: latched on acceptance, shifted right as each data bit ends.
  always_ff @(posedge clk) begin
    if (state == UART_IDLE && tx_valid) begin
      shreg <= tx_data;
    end else if (state == UART_DATA && bit_done && bit_idx != 3'd7) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: rtl/loan_io_ctrl.sv
// HPS loan-IO controller: UART TX on pin 49, RX sense on 50, LED on 53, key on 54.
module loan_io_ctrl
  import loan_io_pkg::*;
#(
  parameter int BAUD_DIV        = 434,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HALF      = 12500000,
  parameter int ACT_HOLD        = 2500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LOAN_W-1:0] loan_in,
  output logic [LOAN_W-1:0] loan_out,
  output logic [LOAN_W-1:0] loan_oe,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              rx_level,
  output logic              key_pressed,
  output logic              key_press,
  input  logic [1:0]        led_mode,
  input  logic              activity
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int SW = $clog2(ACT_HOLD + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [SW-1:0] HOLD_LOAD  = SW'(ACT_HOLD);

  logic          tx_line;
  logic          rx_sync_p0, rx_sync_p1;
  logic          key_sync_p0, key_sync_p1;
  logic          key_stable;
  logic [DW-1:0] deb_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_led;
  logic [SW-1:0] stretch_cnt;
  logic          led;
  logic          unused_pins;

  // Only the RX and key pins are sensed; the rest of the input bus is ignored.
  assign unused_pins = ^loan_in;

  loan_io_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_line  (tx_line)
  );

  // Two-flop synchronizers for the RX and key pins, idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_p0  <= 1'b1;
      rx_sync_p1  <= 1'b1;
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0  <= loan_in[PIN_RX];
      rx_sync_p1  <= rx_sync_p0;
      key_sync_p0 <= loan_in[PIN_KEY];
      key_sync_p1 <= key_sync_p0;
    end
  end

  assign rx_level = rx_sync_p1;

  // Key debounce: a differing sample must persist DEBOUNCE_CYCLES clocks to be accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_stable <= 1'b1;
      deb_cnt    <= '0;
      key_press  <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (key_sync_p1 == key_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt    <= '0;
        key_stable <= key_sync_p1;
        key_press  <= ~key_sync_p1;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign key_pressed = ~key_stable;

  // Free-running blink divider, independent of the selected LED mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_led <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_led <= ~blink_led;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Activity stretcher: reload on each pulse, count down and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stretch_cnt <= '0;
    end else if (activity) begin
      stretch_cnt <= HOLD_LOAD;
    end else if (stretch_cnt != '0) begin
      stretch_cnt <= stretch_cnt - 1'b1;
    end
  end

  // LED output register, selected by mode one clock after it changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= 1'b0;
    end else begin
      case (led_mode)
        LED_OFF:   led <= 1'b0;
        LED_ON:    led <= 1'b1;
        LED_BLINK: led <= blink_led;
        LED_ACT:   led <= (stretch_cnt != '0);
        default:   led <= 1'b0;
      endcase
    end
  end

  // Output bus: only the TX and LED pins are driven.
  always_comb begin
    loan_out          = '0;
    loan_oe           = '0;
    loan_out[PIN_TX]  = tx_line;
    loan_out[PIN_LED] = led;
    loan_oe[PIN_TX]   = 1'b1;
    loan_oe[PIN_LED]  = 1'b1;
  end

endmodule

// File: tb/tb_loan_io_ctrl.sv
// Directed self-checking bench for loan_io_ctrl with small timing parameters.
module tb_loan_io_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [66:0] loan_in;
  logic [66:0] loan_out;
  logic [66:0] loan_oe;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        rx_level;
  logic        key_pressed;
  logic        key_press;
  logic [1:0]  led_mode;
  logic        activity;

  int passes = 0;
  int total  = 0;
  logic [66:0] oe_exp;
  logic        led_ref;
  int          found;

  loan_io_ctrl #(
    .BAUD_DIV        (4),
    .DEBOUNCE_CYCLES (8),
    .BLINK_HALF      (5),
    .ACT_HOLD        (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .loan_in     (loan_in),
    .loan_out    (loan_out),
    .loan_oe     (loan_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_level    (rx_level),
    .key_pressed (key_pressed),
    .key_press   (key_press),
    .led_mode    (led_mode),
    .activity    (activity)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected TX line k clocks after the accepting edge (k = 1 is the first sample).
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    if (k <= 4)       return 1'b0;
    else if (k <= 36) return b[(k - 5) / 4];
    else              return 1'b1;
  endfunction

  initial begin
    oe_exp      = '0;
    oe_exp[49]  = 1'b1;
    oe_exp[53]  = 1'b1;
    reset       = 1'b1;
    loan_in     = '1;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    led_mode    = 2'b00;
    activity    = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_tx", loan_out[49], 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_rx", rx_level, 1'b1);
    chk("rst_keyp", key_pressed, 1'b0);
    chk("rst_press", key_press, 1'b0);
    chk("rst_led", loan_out[53], 1'b0);
    chk("rst_oe", loan_oe, oe_exp);
    chk("rst_out_other", loan_out & ~oe_exp, 67'd0);
    reset = 1'b0;
    tick(); tick();
    chk("post_rst_tx", loan_out[49], 1'b1);
    chk("post_rst_ready", tx_ready, 1'b1);

    // RX synchronizer latency
    loan_in[50] = 1'b0;
    tick();
    chk("rx_lat1", rx_level, 1'b1);
    tick();
    chk("rx_lat2", rx_level, 1'b0);
    loan_in[50] = 1'b1;
    tick(); tick();
    chk("rx_back", rx_level, 1'b1);

    // Key glitch of 5 cycles: rejected
    loan_in[54] = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 6) loan_in[54] = 1'b1;
      tick();
      chk("glitch_press", key_press, 1'b0);
      chk("glitch_keyp", key_pressed, 1'b0);
    end

    // Key held low 20 cycles, then released
    loan_in[54] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("press_strobe", key_press, (i == 10));
      chk("press_level", key_pressed, (i >= 10));
    end
    loan_in[54] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("release_strobe", key_press, 1'b0);
      chk("release_level", key_pressed, (i < 10));
    end

    // Single frame 0xA5
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int k = 1; k <= 44; k++) begin
      if (k > 1) tick();
      chk("a5_tx", loan_out[49], exp_tx(k, 8'hA5));
      chk("a5_ready", tx_ready, (k >= 41));
    end
    chk("a5_oe", loan_oe, oe_exp);

    // Back-to-back frames with tx_valid held: 0x00 then 0xFF
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int k = 1; k <= 82; k++) begin
      tick();
      if (k == 1) tx_data = 8'hFF;
      if (k == 42) tx_valid = 1'b0;
      if (k <= 41) begin
        chk("b2b_tx1", loan_out[49], exp_tx(k, 8'h00));
        chk("b2b_rdy1", tx_ready, (k == 41));
      end else begin
        chk("b2b_tx2", loan_out[49], exp_tx(k - 41, 8'hFF));
        chk("b2b_rdy2", tx_ready, (k >= 82));
      end
    end

    // Blink mode: toggle every 5 cycles
    led_mode = 2'b10;
    tick();
    led_ref = loan_out[53];
    found   = 0;
    for (int i = 0; i < 12; i++) begin
      if (found == 0) begin
        tick();
        if (loan_out[53] !== led_ref) found = 1;
      end
    end
    chk("blink_found", found, 1);
    led_ref = loan_out[53];
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("blink", loan_out[53], led_ref ^ logic'((i / 5) % 2));
    end

    // Activity mode: one pulse stretches to 6 cycles
    led_mode = 2'b11;
    tick(); tick();
    chk("act_idle", loan_out[53], 1'b0);
    activity = 1'b1;
    tick();
    activity = 1'b0;
    chk("act_e1", loan_out[53], 1'b0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      chk("act_stretch", loan_out[53], (i <= 7));
    end

    // Reset mid-DATA aborts the frame immediately
    led_mode = 2'b01;
    tick(); tick();
    chk("led_on", loan_out[53], 1'b1);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    chk("mid_data_low", loan_out[49], 1'b0);
    chk("mid_data_ready", tx_ready, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_tx", loan_out[49], 1'b1);
    chk("abort_ready", tx_ready, 1'b1);
    chk("abort_led", loan_out[53], 1'b0);
    chk("abort_keyp", key_pressed, 1'b0);
    chk("abort_press", key_press, 1'b0);
    chk("abort_rx", rx_level, 1'b1);
    chk("abort_oe", loan_oe, oe_exp);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      chk("no_resume_tx", loan_out[49], 1'b1);
      chk("no_resume_rdy", tx_ready, 1'b1);
    end
    chk("final_oe", loan_oe, oe_exp);
    chk("final_out_other", loan_out & ~oe_exp, 67'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
